// File: rtl/vram_arbiter.sv
// Port-B arbiter for the frame-buffer RAM: display fetcher has priority, host shares the rest.
// Optional starvation guard for the host: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int RD_LATENCY   = 2,
    parameter int MAX_DISP_RUN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [31:0]       disp_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [3:0]        host_be,
    input  logic [31:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic [ADDR_W-1:0] address_b,
    output logic [3:0]        byteena_b,
    output logic [31:0]       data_b,
    output logic              wren_b,
    input  logic [31:0]       q_b
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_DISP_RUN < 1 || MAX_DISP_RUN > 255) begin : g_param_check
            $error("vram_arbiter: parameter out of legal range");
        end
    endgenerate

    logic                  host_pri;
    logic                  rd_push;
    logic [RD_LATENCY-1:0] vld_p;
    logic [RD_LATENCY-1:0] own_p;

    // Grants are combinational; host_pri only ever rises in the guard build.
    assign disp_gnt = rst & disp_req & ~(host_pri & host_req);
    assign host_gnt = rst & host_req & (~disp_req | host_pri);
    assign rd_push  = disp_gnt | (host_gnt & ~host_we);

`ifdef VRAM_ARB_STARVE_GUARD_EN
    typedef enum logic {DISP_PRI, HOST_TURN} state_t;

    state_t     state;
    logic [7:0] run_cnt;
    logic [7:0] run_nxt;

    assign host_pri = (state == HOST_TURN);
    assign run_nxt  = run_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DISP_PRI;
            run_cnt <= '0;
        end else begin
            case (state)
                DISP_PRI: begin
                    if (host_gnt || !host_req) begin
                        run_cnt <= '0;
                    end else if (disp_gnt) begin
                        run_cnt <= run_nxt;
                        if (run_nxt == 8'(MAX_DISP_RUN))
                            state <= HOST_TURN;
                    end
                end
                HOST_TURN: begin
                    if (host_gnt || !host_req) begin
                        state   <= DISP_PRI;
                        run_cnt <= '0;
                    end
                end
                default: begin
                    state   <= DISP_PRI;
                    run_cnt <= '0;
                end
            endcase
        end
    end
`else
    assign host_pri = 1'b0;
`endif

    // Stage p0: issue the winning access onto port B and tag it for return routing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address_b <= '0;
            byteena_b <= 4'b1111;
            data_b    <= '0;
            wren_b    <= 1'b0;
            vld_p     <= '0;
            own_p     <= '0;
        end else begin
            wren_b <= 1'b0;
            if (disp_gnt) begin
                address_b <= disp_addr;
                byteena_b <= 4'b1111;
            end else if (host_gnt) begin
                address_b <= host_addr;
                if (host_we) begin
                    byteena_b <= host_be;
                    data_b    <= host_wdata;
                    wren_b    <= 1'b1;
                end else begin
                    byteena_b <= 4'b1111;
                end
            end
            vld_p[0] <= rd_push;
            own_p[0] <= host_gnt;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                own_p[k] <= own_p[k-1];
            end
        end
    end

    // Stage p(RD_LATENCY): capture q_b into the owner's return register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            if (vld_p[RD_LATENCY-1]) begin
                if (own_p[RD_LATENCY-1]) begin
                    host_rvalid <= 1'b1;
                    host_rdata  <= q_b;
                end else begin
                    disp_rvalid <= 1'b1;
                    disp_rdata  <= q_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural port-B RAM and an in-order return scoreboard.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int ADDR_W = 17;
    localparam int LAT    = 2;
    localparam int RUN    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [31:0]       disp_rdata;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [3:0]        host_be = 4'h0;
    logic [31:0]       host_wdata = '0;
    logic              host_gnt;
    logic              host_rvalid;
    logic [31:0]       host_rdata;
    logic [ADDR_W-1:0] address_b;
    logic [3:0]        byteena_b;
    logic [31:0]       data_b;
    logic              wren_b;
    logic [31:0]       q_b;

    vram_arbiter #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT), .MAX_DISP_RUN(RUN)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_be(host_be), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .address_b(address_b), .byteena_b(byteena_b), .data_b(data_b),
        .wren_b(wren_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: address sampled one edge after issue, data registered (2-cycle read latency).
    logic [31:0] mem [int];
    logic [31:0] q_reg;
    assign q_b = q_reg;

    function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        q_reg <= mem.exists(int'(address_b)) ? mem[int'(address_b)] : init_word(address_b);
        if (wren_b)
            mem[int'(address_b)] = merge(mem.exists(int'(address_b)) ? mem[int'(address_b)] : 32'h0,
                                         data_b, byteena_b);
    end

    // Bench-side expectations
    int           checks = 0;
    int           errors = 0;
    logic [32:0]  sb [$];
    logic [31:0]  shadow [int];
    logic         g_disp, g_host;
    int           n_dg = 0, n_hg = 0, n_drv = 0, n_hrv = 0, n_wr = 0;
    int           dg_cyc = 0, drv_cyc = 0, hrv_cyc = 0;

    function automatic logic [31:0] exp_read(input logic [ADDR_W-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
    endfunction

    task automatic sample();
        logic [32:0] e, got;
        g_disp = disp_gnt;
        g_host = host_gnt;
        checks++;
        if (disp_gnt && host_gnt) begin
            errors++;
            $display("FAIL grant_exclusive: disp_gnt=%b host_gnt=%b, required not both high", disp_gnt, host_gnt);
        end
        if (disp_gnt) begin
            sb.push_back({1'b0, exp_read(disp_addr)});
            n_dg++;
            dg_cyc = cyc;
        end
        if (host_gnt) begin
            n_hg++;
            if (host_we)
                shadow[int'(host_addr)] = merge(shadow.exists(int'(host_addr)) ? shadow[int'(host_addr)] : 32'h0,
                                                host_wdata, host_be);
            else
                sb.push_back({1'b1, exp_read(host_addr)});
        end
        if (wren_b) n_wr++;
        if (disp_rvalid || host_rvalid) begin
            checks++;
            got = {host_rvalid, host_rvalid ? host_rdata : disp_rdata};
            if (disp_rvalid && host_rvalid) begin
                errors++;
                $display("FAIL rvalid_exclusive: both rvalid high at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: owner=%0d data=%h with nothing outstanding", got[32], got[31:0]);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL return_route: got owner=%0d data=%h, required owner=%0d data=%h",
                             got[32], got[31:0], e[32], e[31:0]);
                end
            end
            if (disp_rvalid) begin n_drv++; drv_cyc = cyc; end
            if (host_rvalid) begin n_hrv++; hrv_cyc = cyc; end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({disp_gnt, host_gnt, disp_rvalid, host_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_ctrl: gnt/rvalid=%b, required 0000", tag, {disp_gnt, host_gnt, disp_rvalid, host_rvalid});
        end
        checks++;
        if (disp_rdata !== 32'h0 || host_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s_rdata: disp=%h host=%h, required 0", tag, disp_rdata, host_rdata);
        end
        checks++;
        if (address_b !== '0 || byteena_b !== 4'hF || data_b !== 32'h0 || wren_b !== 1'b0) begin
            errors++;
            $display("FAIL %s_portb: addr=%h be=%h data=%h wren=%b, required 0/f/0/0",
                     tag, address_b, byteena_b, data_b, wren_b);
        end
    endtask

    task automatic test_reset();
        disp_req = 1'b1;
        host_req = 1'b1;
        idle(3);
        check_reset_outputs("reset");
        disp_req = 1'b0;
        host_req = 1'b0;
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_single_read();
        int d0, h0;
        d0 = n_drv; h0 = n_hrv;
        disp_req = 1'b1; disp_addr = 17'h00010;
        tick();
        checks++;
        if (g_disp !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: disp_gnt=%b, required 1", g_disp);
        end
        disp_req = 1'b0;
        idle(6);
        checks++;
        if (n_drv - d0 != 1 || n_hrv != h0) begin
            errors++;
            $display("FAIL single_count: disp_rvalid=%0d host_rvalid=%0d, required 1 and 0", n_drv - d0, n_hrv - h0);
        end
        checks++;
        if (drv_cyc - dg_cyc != LAT + 1) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required %0d", drv_cyc - dg_cyc, LAT + 1);
        end
        checks++;
        if (disp_rdata !== 32'hA5A5_0010) begin
            errors++;
            $display("FAIL single_hold: disp_rdata=%h, required a5a50010", disp_rdata);
        end
    endtask

    task automatic test_write_read();
        int w0, d0, h0;
        w0 = n_wr; d0 = n_drv; h0 = n_hrv;
        host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00004; host_be = 4'b0100; host_wdata = 32'h00AB_0000;
        tick();
        host_req = 1'b0; host_we = 1'b0;
        checks++;
        if (g_host !== 1'b1 || wren_b !== 1'b1 || byteena_b !== 4'b0100 || address_b !== 17'h4 || data_b !== 32'h00AB_0000) begin
            errors++;
            $display("FAIL write_issue: gnt=%b wren=%b be=%b addr=%h data=%h, required 1/1/0100/4/00ab0000",
                     g_host, wren_b, byteena_b, address_b, data_b);
        end
        tick();
        checks++;
        if (wren_b !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse: wren_b=%b one cycle later, required 0", wren_b);
        end
        idle(4);
        checks++;
        if (n_wr - w0 != 1 || n_drv != d0 || n_hrv != h0) begin
            errors++;
            $display("FAIL write_side: wren cycles=%0d rvalids=%0d, required 1 and 0", n_wr - w0, (n_drv - d0) + (n_hrv - h0));
        end
        host_req = 1'b1; host_addr = 17'h00004;
        tick();
        host_req = 1'b0;
        idle(5);
        checks++;
        if (n_hrv - h0 != 1 || host_rdata !== 32'h00AB_0000) begin
            errors++;
            $display("FAIL write_readback: rvalids=%0d data=%h, required 1 and 00ab0000", n_hrv - h0, host_rdata);
        end
    endtask

    task automatic test_same_cycle();
        disp_req = 1'b1; disp_addr = 17'h00020;
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00021;
        tick();
        checks++;
        if (g_disp !== 1'b1 || g_host !== 1'b0) begin
            errors++;
            $display("FAIL same_prio: disp_gnt=%b host_gnt=%b, required 1 and 0", g_disp, g_host);
        end
        disp_req = 1'b0;
        tick();
        checks++;
        if (g_host !== 1'b1) begin
            errors++;
            $display("FAIL same_host_next: host_gnt=%b, required 1", g_host);
        end
        host_req = 1'b0;
        idle(6);
        checks++;
        if (hrv_cyc - drv_cyc != 1) begin
            errors++;
            $display("FAIL same_order: host return %0d cycles after display, required 1", hrv_cyc - drv_cyc);
        end
    endtask

    task automatic test_starve();
        int nd, nh, nd_at_host;
        logic resumed, after_host;
        nd = 0; nh = 0; nd_at_host = -1; resumed = 1'b0; after_host = 1'b0;
        disp_req = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00077;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 20; i++) begin
            disp_addr = 17'h00100 + 17'(i);
            tick();
            if (after_host) begin
                resumed = g_disp;
                after_host = 1'b0;
            end
            if (g_disp) nd++;
            if (g_host) begin
                nh++;
                nd_at_host = nd;
                host_req = 1'b0;
                after_host = 1'b1;
            end
        end
        checks++;
        if (nd_at_host != RUN || nh != 1) begin
            errors++;
            $display("FAIL starve_guard: display grants before host=%0d host grants=%0d, required %0d and 1", nd_at_host, nh, RUN);
        end
        checks++;
        if (resumed !== 1'b1) begin
            errors++;
            $display("FAIL starve_resume: disp_gnt after host turn=%b, required 1", resumed);
        end
`else
        for (int i = 0; i < 100; i++) begin
            disp_addr = 17'h00100 + 17'(i);
            tick();
            if (g_disp) nd++;
            if (g_host) nh++;
        end
        checks++;
        if (nh != 0 || nd != 100) begin
            errors++;
            $display("FAIL starve_strict: host grants=%0d display grants=%0d, required 0 and 100", nh, nd);
        end
`endif
        disp_req = 1'b0; host_req = 1'b0;
        idle(6);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: %0d reads outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_alternating();
        int g0, d0, h0, first_rv, ng;
        g0 = n_dg + n_hg; d0 = n_drv; h0 = n_hrv; ng = 0;
        for (int i = 0; i < 16; i++) begin
            disp_req = (i % 2 == 0);
            host_req = (i % 2 == 1);
            host_we = 1'b0;
            disp_addr = 17'h00200 + 17'(i);
            host_addr = 17'h00300 + 17'(i);
            tick();
            if (g_disp || g_host) ng++;
        end
        disp_req = 1'b0; host_req = 1'b0;
        first_rv = cyc;
        idle(6);
        checks++;
        if (ng != 16 || (n_dg + n_hg) - g0 != 16) begin
            errors++;
            $display("FAIL alt_grants: %0d grants, required 16", ng);
        end
        checks++;
        if (n_drv - d0 != 8 || n_hrv - h0 != 8) begin
            errors++;
            $display("FAIL alt_returns: disp=%0d host=%0d, required 8 and 8", n_drv - d0, n_hrv - h0);
        end
        checks++;
        if (hrv_cyc - first_rv != LAT) begin
            errors++;
            $display("FAIL alt_no_bubble: last return at +%0d after last issue, required +%0d", hrv_cyc - first_rv, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int d0, h0;
        d0 = n_drv; h0 = n_hrv;
        disp_req = 1'b1; disp_addr = 17'h00040;
        tick();
        disp_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00041;
        tick();
        host_req = 1'b0;
        rst = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("midreset");
        idle(2);
        check_reset_outputs("midreset_hold");
        rst = 1'b1;
        idle(8);
        checks++;
        if (n_drv != d0 || n_hrv != h0) begin
            errors++;
            $display("FAIL midreset_drop: rvalids after reset disp=%0d host=%0d, required 0", n_drv - d0, n_hrv - h0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_same_cycle();
        test_starve();
        test_alternating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
